alu_result_serializer: RTL

//  Downstream consumer of the ALU/compare result stage. Captures a WIDTH_IN-bit result on a
//  one-cycle valid pulse and splits it into bytes, LSB first. Hands the bytes one at a time to
//  the UART TX path over a valid/ready handshake. A one-entry holding buffer absorbs a second

---
 rtl/alu_result_serializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_result_serializer.sv
// Serializes WIDTH_IN-bit ALU results into bytes, LSB first, for UART TX.
// Optional frame header byte is enabled by defining ALU_SER_HDR_EN.
//
// Ports:
//   CLK, RST   clock; synchronous active-high reset
//   RES_IN     result word, sampled only when RES_VALID=1
//   RES_VALID  one-cycle result strobe
//   TX_DATA    byte offered downstream (registered)
//   TX_VALID   TX_DATA valid, held until TX_READY
//   TX_READY   downstream accepts when TX_VALID && TX_READY
//   BUSY       frame in flight or hold buffer occupied (registered)
//   OVERFLOW   one-cycle pulse when a result is dropped
module alu_result_serializer #(
  parameter int unsigned     WIDTH_IN = 16,
  parameter logic      [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH_IN-1:0] RES_IN,
  input  logic                RES_VALID,
  output logic [7:0]          TX_DATA,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic                BUSY,
  output logic                OVERFLOW
);

  localparam int unsigned NUM_BYTES = WIDTH_IN / 8;
  localparam int unsigned IW =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef ALU_SER_HDR_EN
  localparam logic [1:0] S_HDR  = 2'd2;
`endif

  logic [1:0]          st, st_n;
  logic [WIDTH_IN-1:0] sr, sr_n;
  logic [IW-1:0]       idx, idx_n, idx_inc;
  logic [WIDTH_IN-1:0] hb, hb_n;
  logic                hb_v, hbv_n;
  logic [7:0]          txd_n;
  logic                txv_n;
  logic                ovf_n;
  logic                accept;
  logic                last;
  logic                load_en;
  logic [WIDTH_IN-1:0] load_val;

  assign accept  = TX_VALID & TX_READY;
  assign last    = (st == S_SEND) && (idx == LAST);
  assign idx_inc = idx + 1'b1;

  always_comb begin
    st_n     = st;
    sr_n     = sr;
    idx_n    = idx;
    hb_n     = hb;
    hbv_n    = hb_v;
    txd_n    = TX_DATA;
    txv_n    = TX_VALID;
    ovf_n    = 1'b0;
    load_en  = 1'b0;
    load_val = RES_IN;

    unique case (1'b1)
      st == S_IDLE: begin
        if (RES_VALID) load_en = 1'b1;
      end
      accept && last: begin
        // Hold buffer has priority; a coincident new result
        // refills it so nothing is lost.
        if (hb_v) begin
          load_en  = 1'b1;
          load_val = hb;
          hbv_n    = RES_VALID;
          if (RES_VALID) hb_n = RES_IN;
        end else if (RES_VALID) begin
          load_en = 1'b1;
        end else begin
          st_n  = S_IDLE;
          txv_n = 1'b0;
        end
      end
      default: begin
        if (accept) begin
`ifdef ALU_SER_HDR_EN
          if (st == S_HDR) begin
            st_n  = S_SEND;
            idx_n = '0;
            txd_n = sr[7:0];
          end else
`endif
          begin
            idx_n = idx_inc;
            txd_n = sr[{idx_inc, 3'b000} +: 8];
          end
        end
        if (RES_VALID) begin
          if (!hb_v) begin
            hb_n  = RES_IN;
            hbv_n = 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
    endcase

    if (load_en) begin
      sr_n  = load_val;
      idx_n = '0;
      txv_n = 1'b1;
`ifdef ALU_SER_HDR_EN
      st_n  = S_HDR;
      txd_n = HDR_BYTE;
`else
      st_n  = S_SEND;
      txd_n = load_val[7:0];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st       <= S_IDLE;
      sr       <= '0;
      idx      <= '0;
      hb       <= '0;
      hb_v     <= 1'b0;
      TX_DATA  <= 8'h00;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      st       <= st_n;
      sr       <= sr_n;
      idx      <= idx_n;
      hb       <= hb_n;
      hb_v     <= hbv_n;
      TX_DATA  <= txd_n;
      TX_VALID <= txv_n;
      BUSY     <= (st_n != S_IDLE) | hbv_n;
      OVERFLOW <= ovf_n;
    end
  end

endmodule
